// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// The winning byte is latched on handshake, so requesters may change their
// inputs afterwards. The serial line is driven from a flop only.
module uart_tx_arbiter #(
  parameter int unsigned CLOCK_RATE = 25000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        frame_done
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // A bit period shorter than two clocks cannot be generated.
  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx_arbiter: CLOCK_RATE/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic [1:0]       grant_q, grant_d;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic             bit_end;

  // State and datapath registers; reset aborts any frame with the line idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      grant_q <= grant_d;
    end
  end

  // Round-robin pick, next-state logic and the registered tx value.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    grant_d   = grant_q;
    req_ready = '0;
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    bit_end   = (cnt_q == CNT_LAST);

    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (found && resetn) begin
          req_ready[win] = 1'b1;
          data_d  = req_data[{win, 3'b000} +: 8];
          grant_d = win;
          ptr_d   = win + 2'd1;
          idx_d   = '0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = data_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign frame_done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with one bit period = 10 clocks.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .CLOCK_RATE(10),
    .BAUD_RATE (1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a negedge with the DUT idle. Drives the request,
  // checks the handshake, then checks all 100 frame cycles and the idle gap.
  task automatic run_frame(input logic [3:0] valid, input logic [31:0] data,
                           input logic [1:0] g, input logic [7:0] b,
                           input bit hold, input logic [3:0] late_valid,
                           input int late_cycle);
    logic [3:0] exp_rdy;
    logic       exp_tx;
    int         bp;
    exp_rdy   = 4'b0001 << g;
    req_valid = valid;
    req_data  = data;
    #1;
    chk("ready_handshake", req_ready, exp_rdy);
    chk("busy_before", busy, 0);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) begin
        req_valid = '0;
        req_data  = ~data;
      end
      if (c == late_cycle) req_valid = late_valid;
      #1;
      bp = (c - 1) / 10;
      if (bp == 0)      exp_tx = 1'b0;
      else if (bp == 9) exp_tx = 1'b1;
      else              exp_tx = b[bp-1];
      chk("tx_bit", tx, exp_tx);
      chk("frame_done", frame_done, (c == 100));
      chk("busy_frame", busy, 1);
      chk("ready_frame", req_ready, 0);
      chk("grant_id", grant_id, g);
    end
    @(negedge clk);
    #1;
    chk("busy_after", busy, 0);
    chk("tx_gap", tx, 1);
    chk("done_gap", frame_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 32'h0000_00A5, 2'd0, 8'hA5};
    vecs[1] = '{4'b0001, 32'h1122_333C, 2'd0, 8'h3C};
    vecs[2] = '{4'b1100, 32'hDE81_0000, 2'd2, 8'h81};
    vecs[3] = '{4'b0110, 32'h0099_7E00, 2'd1, 8'h7E};
    vecs[4] = '{4'b0011, 32'h0000_C35A, 2'd0, 8'h5A};
    vecs[5] = '{4'b0011, 32'h0000_C35A, 2'd1, 8'hC3};
    vecs[6] = '{4'b1111, 32'hFF00_6655, 2'd2, 8'h00};
    vecs[7] = '{4'b1001, 32'hFF00_6655, 2'd3, 8'hFF};

    // Reset state, with every requester asserting valid.
    resetn    = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Table: single bytes, pointer wrap and skip, data change after latch.
    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].valid, vecs[v].data, vecs[v].exp_grant, vecs[v].exp_byte,
                1'b0, 4'b0000, 0);

    // Round robin with all four valid held continuously.
    run_frame(4'b1111, 32'h4433_2211, 2'd0, 8'h11, 1'b1, 4'b1111, 0);
    run_frame(4'b1111, 32'h4433_2211, 2'd1, 8'h22, 1'b1, 4'b1111, 0);
    run_frame(4'b1111, 32'h4433_2211, 2'd2, 8'h33, 1'b1, 4'b1111, 0);
    run_frame(4'b1111, 32'h4433_2211, 2'd3, 8'h44, 1'b1, 4'b1111, 0);
    run_frame(4'b1111, 32'h4433_2211, 2'd0, 8'h11, 1'b1, 4'b1111, 0);
    req_valid = '0;

    // Late request from 3 during requester 1's frame.
    run_frame(4'b0010, 32'h0000_E700, 2'd1, 8'hE7, 1'b0, 4'b1000, 50);
    run_frame(4'b1000, 32'h6B00_0000, 2'd3, 8'h6B, 1'b0, 4'b0000, 0);

    // Reset in the middle of data bit 4 of requester 2's frame.
    req_valid = 4'b0100;
    req_data  = 32'h0086_0000;
    #1;
    chk("rst_seq_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0101;
    req_data  = 32'h0086_003A;
    repeat (54) @(negedge clk);
    #1;
    chk("pre_abort_tx", tx, 0);
    chk("pre_abort_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_grant", grant_id, 0);
    chk("abort_done", frame_done, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_frame(4'b0101, 32'h0086_003A, 2'd0, 8'h3A, 1'b0, 4'b0000, 0);

    // No request pending: the aborted byte must not reappear.
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      chk("no_resend_busy", busy, 0);
      chk("no_resend_tx", tx, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
